// File: rtl/glip_deframer_pkg.sv
// Shared definitions for the GLIP input deframer: parser states, header
// field layout and the keep encodings used on the packed output beats.
package glip_deframer_pkg;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_DROP
    } state_t;

    localparam int TYPE_MSB = 15;
    localparam int TYPE_LSB = 12;
    localparam int TYPE_W   = TYPE_MSB - TYPE_LSB + 1;
    localparam int LEN_W    = 12;

    localparam logic [1:0] KEEP_NONE = 2'b00;
    localparam logic [1:0] KEEP_LOW  = 2'b01;
    localparam logic [1:0] KEEP_FULL = 2'b11;

    // Payload length field of a header word
    function automatic logic [LEN_W-1:0] hdr_len(input logic [15:0] word);
        return word[LEN_W-1:0];
    endfunction

    // Packet type field of a header word
    function automatic logic [TYPE_W-1:0] hdr_type(input logic [15:0] word);
        return word[TYPE_MSB:TYPE_LSB];
    endfunction

endpackage

// File: rtl/glip_in_deframer.sv
// Deframer for the GLIP host-to-device word stream: parses a one-word
// header, packs payload words pairwise into 32-bit beats and silently
// discards packets whose length is zero or larger than MAX_LEN.
module glip_in_deframer
    import glip_deframer_pkg::*;
#(
    parameter int MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_keep,
    output logic [3:0]  out_type,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_zero,
    output logic        err_long
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [15:0]        lo_reg;
    logic [TYPE_W-1:0]  type_reg;
    logic               can_load;
    logic               accept;
    logic [LEN_W-1:0]   len_field;
    logic [LEN_W-1:0]   rem_dec;

    assign can_load  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign len_field = hdr_len(in_data);
    assign rem_dec   = (remaining != '0) ? remaining - ONE : remaining;

    // Accept words freely unless this word would complete a beat while the output stage is still occupied
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                ST_HDR:  in_ready = 1'b1;
                ST_LO:   in_ready = (remaining > ONE) ? 1'b1 : can_load;
                ST_HI:   in_ready = can_load;
                ST_DROP: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Header parsing, payload pairing and the single-stage output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HDR;
            remaining <= '0;
            lo_reg    <= '0;
            type_reg  <= '0;
            out_data  <= '0;
            out_keep  <= KEEP_NONE;
            out_type  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            err_zero  <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_zero <= 1'b0;
            err_long <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    ST_HDR: begin
                        if (len_field == '0) begin
                            err_zero <= 1'b1;
                        end else if (len_field > MAX_LEN_W) begin
                            err_long  <= 1'b1;
                            remaining <= len_field;
                            state     <= ST_DROP;
                        end else begin
                            type_reg  <= hdr_type(in_data);
                            remaining <= len_field;
                            state     <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        remaining <= rem_dec;
                        if (remaining > ONE) begin
                            lo_reg <= in_data;
                            state  <= ST_HI;
                        end else begin
                            out_data  <= {16'h0000, in_data};
                            out_keep  <= KEEP_LOW;
                            out_last  <= 1'b1;
                            out_type  <= type_reg;
                            out_valid <= 1'b1;
                            state     <= ST_HDR;
                        end
                    end
                    ST_HI: begin
                        remaining <= rem_dec;
                        out_data  <= {in_data, lo_reg};
                        out_keep  <= KEEP_FULL;
                        out_last  <= (remaining == ONE);
                        out_type  <= type_reg;
                        out_valid <= 1'b1;
                        state     <= (remaining == ONE) ? ST_HDR : ST_LO;
                    end
                    ST_DROP: begin
                        remaining <= rem_dec;
                        if (remaining == ONE) begin
                            state <= ST_HDR;
                        end
                    end
                    default: state <= ST_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glip_in_deframer.sv
// Self-checking bench for glip_in_deframer: a packet-level model turns the
// accepted word stream into expected beats and error pulses, and a compare
// process checks the DUT against it on every falling clock edge.
module tb_glip_in_deframer;

    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_keep;
    logic [3:0]  out_type;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        err_zero;
    logic        err_long;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;
    int ez_cnt = 0;
    int el_cnt = 0;
    bit rand_ready = 1'b0;

    logic [38:0] exp_q[$];
    logic [38:0] obs_log[$];

    int          m_rem = 0;
    bit          m_drop = 1'b0;
    logic [3:0]  m_type = '0;
    logic [15:0] m_words[$];
    bit          exp_ez = 1'b0;
    bit          exp_el = 1'b0;
    bit          pend_beat = 1'b0;
    bit          prev_stall = 1'b0;
    logic [39:0] prev_out = '0;

    glip_in_deframer #(.MAX_LEN(MAXL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_type  (out_type),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_zero  (err_zero),
        .err_long  (err_long)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] mk(input logic [3:0] t, input logic l, input logic [1:0] k, input logic [31:0] d);
        return {t, l, k, d};
    endfunction

    function automatic logic [38:0] logEntry(input int i);
        if (i < obs_log.size()) return obs_log[i];
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=absent required=present", name);
    endtask

    // Offer one word after `idle` empty cycles and hold it until accepted
    task automatic applyStimulus(input logic [15:0] w, input int idle);
        bit acc;
        int n;
        in_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = w;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else stall_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) failNow("accept_timeout");
    endtask

    // Wait until every expected beat has been delivered and the output is empty
    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) failNow("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output-ready driver: held high or randomised per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Packet model and per-cycle compare against the DUT
    initial begin : compare
        logic [15:0] w;
        int len;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("reset_outputs",
                    {out_valid, out_data, out_keep, out_type, out_last, err_zero, err_long, in_ready}, '0);
                exp_q.delete();
                m_words.delete();
                m_rem = 0;
                m_drop = 1'b0;
                exp_ez = 1'b0;
                exp_el = 1'b0;
                pend_beat = 1'b0;
                prev_stall = 1'b0;
            end else begin
                checkOutput("err_zero", err_zero, exp_ez);
                checkOutput("err_long", err_long, exp_el);
                if (err_zero) ez_cnt++;
                if (err_long) el_cnt++;
                exp_ez = 1'b0;
                exp_el = 1'b0;
                if (pend_beat) checkOutput("beat_latency", out_valid, 1'b1);
                pend_beat = 1'b0;
                if (prev_stall)
                    checkOutput("stall_stable", {out_valid, out_type, out_last, out_keep, out_data}, prev_out);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        failNow("unexpected_beat_absent_in_model");
                    end else begin
                        checkOutput("beat", {out_type, out_last, out_keep, out_data}, exp_q.pop_front());
                    end
                    obs_log.push_back({out_type, out_last, out_keep, out_data});
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {out_valid, out_type, out_last, out_keep, out_data};
                if (in_valid && in_ready) begin
                    w = in_data;
                    if (m_rem == 0) begin
                        len = int'(w[11:0]);
                        if (len == 0) begin
                            exp_ez = 1'b1;
                        end else if (len > MAXL) begin
                            exp_el = 1'b1;
                            m_rem = len;
                            m_drop = 1'b1;
                        end else begin
                            m_rem = len;
                            m_drop = 1'b0;
                            m_type = w[15:12];
                            m_words.delete();
                        end
                    end else begin
                        m_rem--;
                        if (!m_drop) begin
                            m_words.push_back(w);
                            if (m_words.size() == 2) begin
                                exp_q.push_back(mk(m_type, m_rem == 0, 2'b11, {m_words[1], m_words[0]}));
                                pend_beat = 1'b1;
                                m_words.delete();
                            end else if (m_rem == 0) begin
                                exp_q.push_back(mk(m_type, 1'b1, 2'b01, {16'h0000, m_words[0]}));
                                pend_beat = 1'b1;
                                m_words.delete();
                            end
                        end
                    end
                end
            end
        end
    end

    // Hard stop in case something wedges the directed sequence
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    // Directed packet sequence with literal expectations that pin the model
    initial begin : stim
        logic [15:0] t5[9];
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back even and odd packets at full rate
        stall_cnt = 0;
        obs_log.delete();
        applyStimulus(16'h3004, 0);
        applyStimulus(16'h1111, 0);
        applyStimulus(16'h2222, 0);
        applyStimulus(16'h3333, 0);
        applyStimulus(16'h4444, 0);
        applyStimulus(16'h5003, 0);
        applyStimulus(16'h000A, 0);
        applyStimulus(16'h000B, 0);
        applyStimulus(16'h000C, 0);
        waitDrain();
        checkOutput("t1_no_stall", stall_cnt, 0);
        checkOutput("t1_beats", obs_log.size(), 4);
        checkOutput("t1_beat0", logEntry(0), mk(4'h3, 1'b0, 2'b11, 32'h22221111));
        checkOutput("t1_beat1", logEntry(1), mk(4'h3, 1'b1, 2'b11, 32'h44443333));
        checkOutput("t2_beat0", logEntry(2), mk(4'h5, 1'b0, 2'b11, 32'h000B000A));
        checkOutput("t2_beat1", logEntry(3), mk(4'h5, 1'b1, 2'b01, 32'h0000000C));

        // Zero-length header followed by a single-word packet
        obs_log.delete();
        ez_cnt = 0;
        applyStimulus(16'h1000, 0);
        applyStimulus(16'h2001, 0);
        applyStimulus(16'hBEEF, 0);
        waitDrain();
        checkOutput("t3_zero_pulses", ez_cnt, 1);
        checkOutput("t3_beats", obs_log.size(), 1);
        checkOutput("t3_beat0", logEntry(0), mk(4'h2, 1'b1, 2'b01, 32'h0000BEEF));

        // Length MAX_LEN+1 is dropped, next packet survives
        obs_log.delete();
        el_cnt = 0;
        applyStimulus(16'h7009, 0);
        for (int i = 0; i < 9; i++) applyStimulus(16'hD000 + 16'(i), 0);
        applyStimulus(16'h1002, 0);
        applyStimulus(16'hAAAA, 0);
        applyStimulus(16'hBBBB, 0);
        waitDrain();
        checkOutput("t4_long_pulses", el_cnt, 1);
        checkOutput("t4_beats", obs_log.size(), 1);
        checkOutput("t4_beat0", logEntry(0), mk(4'h1, 1'b1, 2'b11, 32'hBBBBAAAA));

        // Length exactly MAX_LEN under random backpressure and input gaps
        obs_log.delete();
        rand_ready = 1'b1;
        t5[0] = 16'h3008;
        for (int i = 1; i < 9; i++) t5[i] = 16'h8000 + 16'(i);
        for (int i = 0; i < 9; i++) applyStimulus(t5[i], $urandom_range(0, 2));
        waitDrain();
        rand_ready = 1'b0;
        checkOutput("t5_beats", obs_log.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("t5_beat", logEntry(i),
                mk(4'h3, i == 3, 2'b11, {16'h8002 + 16'(2 * i), 16'h8001 + 16'(2 * i)}));

        // Reset in the middle of a packet, then a fresh packet
        applyStimulus(16'h3006, 0);
        applyStimulus(16'h0001, 0);
        applyStimulus(16'h0002, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_log.delete();
        applyStimulus(16'h2002, 0);
        applyStimulus(16'h0123, 0);
        applyStimulus(16'h4567, 0);
        waitDrain();
        checkOutput("t6_beats", obs_log.size(), 1);
        checkOutput("t6_beat0", logEntry(0), mk(4'h2, 1'b1, 2'b11, 32'h45670123));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
